// File: rtl/uart_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_pkg
//   Definitions shared by the UART receive front-end and the matching
//   transmitter: the deframer state encoding and the helper functions that
//   turn the clock / bit-rate parameters into counter limits and widths.
//   No ports (package).
// ---------------------------------------------------------------------------
package uart_rx_fifo_pkg;

    // Deframer / framer state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Clock cycles spent on one bit on the line (434 for 50 MHz / 115200).
    function automatic int cycles_per_bit(input int clk_freq, input int bit_rate);
        return clk_freq / bit_rate;
    endfunction

    // Bits needed to hold the values 0..value-1 (ceil(log2(value))).
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
//   Valid/ready byte stream between the UART receive FIFO and its consumer
//   (the Controller's command parser).
//   Signals:
//     data_out    producer -> consumer  head-of-FIFO character
//     data_valid  producer -> consumer  data_out holds a character
//     data_ready  consumer -> producer  consumer takes data_out this cycle
//   Modports: master = producer (receiver), slave = consumer.
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int PAYLOAD_BITS = 8
);

    logic [PAYLOAD_BITS-1:0] data_out;
    logic                    data_valid;
    logic                    data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is held in a
//   register so pop_data is a clean flop output that resets to zero and
//   holds its last value while the FIFO is empty.
//   Ports:
//     clk, reset  clock and synchronous active-high reset
//     push        write push_data (ignored when full unless popping too)
//     push_data   character to store
//     pop         consumer takes pop_data (ignored when empty)
//     pop_data    head-of-FIFO entry, meaningful while empty = 0
//     full        count == DEPTH
//     empty       count == 0
//     count       number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8        // power of two, >= 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [clog2(DEPTH):0]    count
);

    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign rd_next = rd_ptr + 1'b1;     // wraps modulo DEPTH

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: storage has no reset; count and the pointers decide which entries
    // are live, and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pop_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end

            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Keep the head register equal to the entry at the read pointer.
            if (empty) begin
                if (do_push) begin
                    pop_data <= push_data;
                end
            end else if (do_pop) begin
                if (count != (PTR_W + 1)'(1)) begin
                    pop_data <= mem[rd_next];
                end else if (do_push) begin
                    pop_data <= push_data;
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   UART receive front-end for the Controller's command parser. Synchronises
//   the board rx pin, deframes 8N1 characters (LSB first, sampled mid-bit)
//   and queues them in a FWFT FIFO presented as a valid/ready stream.
//   Ports:
//     clk          system clock (50 MHz), all logic on posedge
//     reset        synchronous, active-high
//     rx           asynchronous UART line, idle high
//     stream       master side of the byte stream (data_out/data_valid/data_ready)
//     frame_error  1-cycle pulse: stop bit sampled low, character discarded
//     overflow     1-cycle pulse: character dropped because the FIFO was full
//     rx_busy      deframer is inside a character (not IDLE)
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8,
    parameter int BUFFER_SIZE  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    uart_rx_fifo_if.master        stream,
    output logic                  frame_error,
    output logic                  overflow,
    output logic                  rx_busy
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_FREQ, BIT_RATE);
    localparam int CNT_W          = clog2(CYCLES_PER_BIT);
    localparam int IDX_W          = clog2(PAYLOAD_BITS);
    localparam int COUNT_W        = clog2(BUFFER_SIZE) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAYLOAD_BITS - 1);

    // -----------------------------------------------------------------------
    // rx synchroniser; preset to the idle level so reset never looks like a
    // start bit.
    // -----------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;

    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // which is what turns these two statements into a two-stage shift chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // -----------------------------------------------------------------------
    // Deframer FSM with its bit-period counter and shift register.
    // -----------------------------------------------------------------------
    uart_state_t             state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [PAYLOAD_BITS-1:0] shift_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            frame_error <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end

                // Re-check the line half a bit in; a short low pulse is noise.
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Counter now runs from mid-bit to mid-bit; data arrives LSB first.
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        shift_reg <= {rx_s, shift_reg[PAYLOAD_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            state   <= STOP;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Leave at mid stop bit so a back-to-back start edge is not missed.
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt         <= '0;
                        state       <= IDLE;
                        rx_busy     <= 1'b0;
                        frame_error <= !rx_s;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    // A good stop sample writes the character straight into the FIFO, so it
    // is visible on the stream the following cycle.
    logic push;
    assign push = (state == STOP) && (cnt == BIT_LAST) && rx_s;

    // -----------------------------------------------------------------------
    // Character FIFO and stream side.
    // -----------------------------------------------------------------------
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [COUNT_W-1:0]      fifo_count;
    logic [PAYLOAD_BITS-1:0] fifo_head;

    assign pop = !fifo_empty && stream.data_ready;

    sync_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (BUFFER_SIZE)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift_reg),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign stream.data_out   = fifo_head;
    assign stream.data_valid = (fifo_count != '0);

    // A full FIFO only drops the character when nothing leaves that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= push && fifo_full && !pop;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CPB        = 434;                  // 50 MHz / 115200
    localparam int DEPTH      = 8;
    // Edges from the first clock that sees the start bit to the stop-sample
    // edge: 2 synchroniser + half bit + 9 full bits (8 data + stop).
    localparam int PUSH_LAT   = 2 + CPB / 2 + 9 * CPB;
    // Edges from that clock until a rejected start returns to idle.
    localparam int GLITCH_LAT = 2 + CPB / 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;
    logic frame_error;
    logic overflow;
    logic rx_busy;

    uart_rx_fifo_if #(.PAYLOAD_BITS(8)) stream ();

    uart_rx_fifo #(
        .CLK_FREQ     (50000000),
        .BIT_RATE     (115200),
        .PAYLOAD_BITS (8),
        .BUFFER_SIZE  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .stream      (stream),
        .frame_error (frame_error),
        .overflow    (overflow),
        .rx_busy     (rx_busy)
    );

    always #10 clk = ~clk;

    // ---------------------------------------------------------------------
    // Checking infrastructure
    // ---------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: frames are scheduled by time stamp (the edge at
    // which their stop bit is judged); the FIFO is a plain queue.
    // ---------------------------------------------------------------------
    typedef struct {
        int         at;
        logic [7:0] data;
        bit         good;
    } frame_t;

    frame_t     pend[$];
    logic [7:0] mq[$];
    logic [7:0] logq[$];       // characters the DUT handed to the consumer
    int         cyc       = 0;
    int         busy_from = 0;
    int         busy_to   = 0;
    bit         busy_chk  = 1'b1;
    int         fe_seen   = 0;
    int         ov_seen   = 0;
    int         valid_seen = 0;

    initial begin : compare
        bit         m_pop;
        bit         m_push;
        bit         exp_fe;
        bit         exp_ov;
        bit         in_reset;
        bit         prev_valid;
        logic [7:0] prev_dout;
        frame_t     head;
        prev_valid = 1'b0;
        prev_dout  = 8'h00;
        forever begin
            @(posedge clk);
            cyc      = cyc + 1;
            m_pop    = 1'b0;
            m_push   = 1'b0;
            exp_fe   = 1'b0;
            exp_ov   = 1'b0;
            in_reset = reset;
            if (reset) begin
                mq.delete();
                pend.delete();
                busy_from = 0;
                busy_to   = 0;
            end else begin
                m_pop = (mq.size() != 0) && stream.data_ready;
                if (m_pop && prev_valid) logq.push_back(prev_dout);
                if (pend.size() != 0 && pend[0].at == cyc) begin
                    head = pend.pop_front();
                    if (!head.good)                            exp_fe = 1'b1;
                    else if (mq.size() == DEPTH && !m_pop)     exp_ov = 1'b1;
                    else                                       m_push = 1'b1;
                end
                if (m_pop)  void'(mq.pop_front());
                if (m_push) mq.push_back(head.data);
            end
            #1;
            check("data_valid", stream.data_valid, mq.size() != 0);
            if (mq.size() != 0)
                check("data_out", stream.data_out, mq[0]);
            else if (in_reset)
                check("data_out_reset", stream.data_out, 8'h00);
            check("frame_error", frame_error, exp_fe);
            check("overflow", overflow, exp_ov);
            if (busy_chk)
                check("rx_busy", rx_busy, (cyc >= busy_from) && (cyc < busy_to));
            prev_valid = stream.data_valid;
            prev_dout  = stream.data_out;
            fe_seen    = fe_seen + int'(frame_error);
            ov_seen    = ov_seen + int'(overflow);
            valid_seen = valid_seen + int'(stream.data_valid);
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge)
    // ---------------------------------------------------------------------
    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        frame_t f;
        int     start;
        start  = cyc + 1;
        f.at   = start + PUSH_LAT;
        f.data = d;
        f.good = stop_ok;
        pend.push_back(f);
        busy_from = start + 2;
        busy_to   = start + PUSH_LAT;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_glitch(input int len);
        int start;
        start     = cyc + 1;
        busy_from = start + 2;
        busy_to   = start + GLITCH_LAT;
        rx = 1'b0;
        repeat (len) @(negedge clk);
        rx = 1'b1;
    endtask

    // Start a frame, then reset the block half-way through data bit 4.
    task automatic send_then_reset(input logic [7:0] d);
        frame_t f;
        int     start;
        start  = cyc + 1;
        f.at   = start + PUSH_LAT;
        f.data = d;
        f.good = 1'b1;
        pend.push_back(f);
        busy_from = start + 2;
        busy_to   = start + PUSH_LAT;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = d[4];
        repeat (CPB / 2) @(negedge clk);
        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_rst_valid", stream.data_valid, 1'b0);
        check("t6_rst_dout", stream.data_out, 8'h00);
        check("t6_rst_busy", rx_busy, 1'b0);
        check("t6_rst_fe_ov", {frame_error, overflow}, 2'b00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        stream.data_ready = 1'b1;
        repeat (n) @(negedge clk);
        stream.data_ready = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin : main
        logic [7:0] exp2 [3];
        logic [7:0] exp5 [9];
        int         fe0;
        int         ov0;
        int         v0;
        exp2 = '{8'h00, 8'hFF, 8'h3C};
        exp5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hAA};
        stream.data_ready = 1'b0;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_valid", stream.data_valid, 1'b0);
        check("rst_dout", stream.data_out, 8'h00);
        check("rst_pulses", {frame_error, overflow, rx_busy}, 3'b000);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // 1. Single character straight through a ready consumer
        logq.delete();
        fe0 = fe_seen; ov0 = ov_seen; v0 = valid_seen;
        stream.data_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        stream.data_ready = 1'b0;
        check("t1_count", logq.size(), 1);
        if (logq.size() == 1) check("t1_data", logq[0], 8'hA5);
        check("t1_valid_cycles", valid_seen - v0, 1);
        check("t1_no_pulses", (fe_seen - fe0) + (ov_seen - ov0), 0);

        // 2. Back-to-back characters into a stalled consumer
        logq.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        check("t2_queued", mq.size(), 3);
        check("t2_valid", stream.data_valid, 1'b1);
        drain(10);
        check("t2_popped", logq.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < logq.size()) check("t2_order", logq[i], exp2[i]);

        // 3. Short low glitch on an idle line
        repeat (20) @(negedge clk);
        logq.delete();
        send_glitch(100);
        repeat (218) @(negedge clk);
        check("t3_busy_clear", rx_busy, 1'b0);
        check("t3_no_char", stream.data_valid, 1'b0);
        repeat (20) @(negedge clk);

        // 4. Stop bit held low; the line re-triggers a start that is rejected,
        //    so busy is not tracked until the line has settled.
        fe0 = fe_seen;
        busy_chk = 1'b0;
        send_frame(8'h81, 1'b0);
        repeat (500) @(negedge clk);
        busy_chk = 1'b1;
        check("t4_fe_once", fe_seen - fe0, 1);
        check("t4_fifo_empty", stream.data_valid, 1'b0);
        check("t4_busy_idle", rx_busy, 1'b0);

        // 5. Fill past capacity, then push into a full FIFO while popping
        logq.delete();
        ov0 = ov_seen;
        for (int i = 1; i <= 9; i++) send_frame(8'(i * 8'h11), 1'b1);
        check("t5_full", mq.size(), DEPTH);
        check("t5_overflow_once", ov_seen - ov0, 1);
        repeat (20) @(negedge clk);
        fork
            send_frame(8'hAA, 1'b1);
            begin
                repeat (PUSH_LAT) @(negedge clk);
                stream.data_ready = 1'b1;
                @(negedge clk);
                stream.data_ready = 1'b0;
            end
        join
        check("t5_no_second_ovf", ov_seen - ov0, 1);
        check("t5_still_full", mq.size(), DEPTH);
        drain(20);
        check("t5_popped", logq.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < logq.size()) check("t5_order", logq[i], exp5[i]);

        // 6. Reset in the middle of a frame, then a clean character
        repeat (20) @(negedge clk);
        logq.delete();
        send_then_reset(8'hC3);
        repeat (20) @(negedge clk);
        stream.data_ready = 1'b1;
        send_frame(8'h5A, 1'b1);
        repeat (20) @(negedge clk);
        stream.data_ready = 1'b0;
        check("t6_count", logq.size(), 1);
        if (logq.size() == 1) check("t6_data", logq[0], 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #(20 * 120000);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
